ctrl_unit_mc: RTL and testbench
===============================

Name: ctrl_unit_mc

Overview:
- Registered, multi-cycle control unit for the 8-bit CPU; replaces the purely combinational opcode decoder.
- Decodes the full 12-opcode ISA: loadi, mov, add, sub, and, or, j, beq, lwd, lwi, swd, swi.
- Sequences data-memory accesses with a BUSYWAIT handshake and stalls the PC during them.
- Sits between the instruction fetch stage and the register file, ALU, PC mux and data memory.

Parameters:
- OPCODE_W, 8: width of the opcode field in INSTRUCTION[OPCODE_W-1:0].
- ALUOP_W, 3: width of ALUOP.
- TIMEOUT_CYCLES, 16: max BUSYWAIT cycles before abort; used only with CTRL_MEM_TIMEOUT_EN; legal range 2..255.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- INSTRUCTION  in  32  current instruction; opcode is [OPCODE_W-1:0].
- INSTR_VALID  in  1  INSTRUCTION is valid this cycle.
- BUSYWAIT  in  1  data memory busy.
- WRITEENABLE  out  1  register-file write strobe.
- ALUOP  out  ALUOP_W  ALU select: 000 fwd, 001 add, 010 and, 011 or.
- COMPLEMENT_FLAG  out  1  select two's-complement of operand 2.
- IMMEDIATE_FLAG  out  1  select the immediate as operand 2.
- MEM_TO_REG  out  1  select memory read data for the writeback.
- JUMP  out  1  unconditional PC redirect.
- BRANCH  out  1  conditional redirect; the PC logic qualifies it with ALU zero.
- MEM_READ  out  1  data-memory read request.
- MEM_WRITE  out  1  data-memory write request.
- PC_STALL  out  1  fetch must hold the PC and INSTRUCTION.
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode.
- MEM_ERR  out  1  one-cycle pulse on memory timeout; tied 0 without the macro.

Behaviour:
- All outputs are registered.
- Reset (RESET=0, asynchronous): every output goes to 0 and state goes to S_DEC. This includes reset asserted mid-access, which aborts the access with no writeback.
- States:
  - S_DEC: accept an instruction.
  - S_MEM: memory access in progress.
  - S_WB: load writeback.
- S_DEC, INSTR_VALID=1 at a CLK edge: outputs are valid one cycle after the edge (latency 1).
  - loadi: WE=1, ALUOP=000, IMM=1.
  - mov: WE=1, ALUOP=000.
  - add: WE=1, ALUOP=001.
  - sub: WE=1, ALUOP=001, COMP=1.
  - and: WE=1, ALUOP=010.
  - or: WE=1, ALUOP=011.
  - j: JUMP=1, WE=0.
  - beq: BRANCH=1, ALUOP=001, COMP=1, WE=0.
  - lwd/lwi: MEM_READ=1, ALUOP=000, IMM=1 for lwi, PC_STALL=1, go to S_MEM.
  - swd/swi: MEM_WRITE=1, ALUOP=000, IMM=1 for swi, PC_STALL=1, go to S_MEM.
  - Opcode >11: ILLEGAL=1 for one cycle, all enables 0, stay in S_DEC.
- WE, JUMP, BRANCH and ILLEGAL are single-cycle pulses. They return to 0 the next cycle unless the next instruction re-asserts them.
- S_DEC, INSTR_VALID=0: all strobes are 0. ALUOP and the flags hold their last values.
- S_MEM:
  - MEM_READ/MEM_WRITE, ALUOP, IMM and PC_STALL hold.
  - BUSYWAIT is ignored on the first S_MEM edge (request cycle).
  - On any later edge with BUSYWAIT=0: deassert MEM_READ/MEM_WRITE. A load goes to S_WB; a store goes to S_DEC with PC_STALL=0.
- S_WB: WE=1, MEM_TO_REG=1, PC_STALL=1 for exactly one cycle. Then go to S_DEC with PC_STALL=0 and MEM_TO_REG=0.
- INSTR_VALID is ignored in S_MEM and S_WB, so there is no lost or duplicate decode.
- Back-to-back ALU instructions: one instruction per cycle, no bubbles.
- Opcode bits above bit 3 that are nonzero count as illegal (for OPCODE_W=8).

Optional Feature:
- Macro: CTRL_MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter counts S_MEM cycles.
  - If BUSYWAIT is still 1 on the TIMEOUT_CYCLES-th S_MEM edge: MEM_ERR pulses 1 cycle, MEM_READ/MEM_WRITE clear, no writeback, state goes to S_DEC, PC_STALL=0.
  - The counter clears on every S_MEM entry and on reset.
- Undefined: MEM_ERR is constant 0 and S_MEM waits indefinitely.

Test Plan:
- Reset and ALU stream:
  - RESET=0 mid-stream -> all outputs 0 immediately.
  - Release, then loadi(00), add(02), sub(03) on consecutive cycles -> WE=1 on 3 consecutive cycles.
  - ALUOP 000, 001, 001; IMM 1, 0, 0; COMP 0, 0, 1.
- Load with 3-cycle BUSYWAIT:
  - lwd(08) -> MEM_READ=1 and PC_STALL=1 for 4 cycles.
  - Then WE=1 and MEM_TO_REG=1 for exactly 1 cycle.
  - PC_STALL=0 the following cycle; INSTR_VALID pulses during the stall are ignored.
- Store:
  - swi(0B) with BUSYWAIT=0 throughout -> MEM_WRITE=1 and IMM=1 for 2 cycles (request + complete).
  - WE never 1; PC_STALL=0 on the third cycle.
- Control flow and illegal opcode:
  - j(06) -> JUMP=1 for 1 cycle.
  - beq(07) -> BRANCH=1, ALUOP=001, COMP=1.
  - opcode 0x1F -> ILLEGAL=1 for 1 cycle, WE=0.
- Reset mid-access: lwi(09), BUSYWAIT=1, RESET=0 on the 2nd S_MEM cycle -> MEM_READ=0 at once, no WE pulse after release.
- Timeout (macro on, TIMEOUT_CYCLES=4): lwd with BUSYWAIT stuck at 1 -> MEM_ERR=1 on the 4th S_MEM edge, no WE, state returns to S_DEC.

Source files
------------

// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: registered multi-cycle control unit for the 8-bit CPU.
// Decodes loadi/mov/add/sub/and/or/j/beq/lwd/lwi/swd/swi and sequences
// data-memory accesses with a BUSYWAIT handshake, stalling fetch meanwhile.
//
// Optional feature macro: CTRL_MEM_TIMEOUT_EN (memory access timeout, MEM_ERR).
//
// Ports:
//   CLK, RESET (async, active low)
//   INSTRUCTION[31:0], INSTR_VALID  - instruction from fetch, opcode in [OPCODE_W-1:0]
//   BUSYWAIT                        - data memory busy
//   WRITEENABLE, ALUOP, COMPLEMENT_FLAG, IMMEDIATE_FLAG, MEM_TO_REG - datapath controls
//   JUMP, BRANCH                    - PC redirect requests
//   MEM_READ, MEM_WRITE             - data memory requests
//   PC_STALL                        - fetch holds PC and INSTRUCTION
//   ILLEGAL, MEM_ERR                - one-cycle error pulses
module ctrl_unit_mc #(
  parameter int OPCODE_W       = 8,
  parameter int ALUOP_W        = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        INSTRUCTION,
  input  logic               INSTR_VALID,
  input  logic               BUSYWAIT,
  output logic               WRITEENABLE,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               COMPLEMENT_FLAG,
  output logic               IMMEDIATE_FLAG,
  output logic               MEM_TO_REG,
  output logic               JUMP,
  output logic               BRANCH,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic               PC_STALL,
  output logic               ILLEGAL,
  output logic               MEM_ERR
);

  typedef enum logic [1:0] {S_DEC, S_MEM, S_WB} state_t;

  typedef struct packed {
    logic               we;
    logic [ALUOP_W-1:0] aluop;
    logic               comp;
    logic               imm;
    logic               mtr;
    logic               jump;
    logic               branch;
    logic               mrd;
    logic               mwr;
    logic               stall;
    logic               ill;
  } ctrl_t;

  localparam logic [ALUOP_W-1:0] ALU_FWD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   first_q, first_d;  // high on the request edge of an access, where BUSYWAIT is not yet meaningful

  logic [OPCODE_W-1:0] opcode;
  logic [3:0]          op_lo;
  logic                legal;
  logic                done;    // access completes this edge
  logic                tmo;     // access aborts this edge

  assign opcode = INSTRUCTION[OPCODE_W-1:0];
  assign op_lo  = opcode[3:0];
  // Any nonzero bit above bit 3 makes the opcode undefined.
  assign legal  = (opcode < OPCODE_W'(12));

  // Operand fields belong to the datapath; only the opcode matters here.
  logic unused_bits;
  assign unused_bits = ^{1'b0, INSTRUCTION[31:OPCODE_W], 8'(TIMEOUT_CYCLES)};

  assign done = (state_q == S_MEM) && !first_q && !BUSYWAIT;

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;  // S_MEM edges already taken in this access
  logic       merr_q, merr_d;
  // cnt_q == N-1 means the current edge is the N-th S_MEM edge.
  assign tmo    = (state_q == S_MEM) && BUSYWAIT && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign cnt_d  = (state_q == S_MEM) ? cnt_q + 8'd1 : 8'd0;
  assign merr_d = tmo;
  assign MEM_ERR = merr_q;
`else
  assign tmo     = 1'b0;
  assign MEM_ERR = 1'b0;
`endif

  // State register (also holds the registered outputs)
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_DEC;
      ctrl_q  <= '0;
      first_q <= 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
      merr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      first_q <= first_d;
`ifdef CTRL_MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      merr_q  <= merr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    unique case (state_q)
      S_DEC: if (INSTR_VALID && legal && op_lo[3]) begin
        state_d = S_MEM;
        first_d = 1'b1;
      end
      S_MEM: begin
        if (done)     state_d = ctrl_q.mrd ? S_WB : S_DEC;
        else if (tmo) state_d = S_DEC;
      end
      S_WB:    state_d = S_DEC;
      default: state_d = S_DEC;
    endcase
  end

  // Output logic: next value of every registered control output
  always_comb begin
    ctrl_d        = ctrl_q;  // ALUOP / COMP / IMM hold unless re-decoded
    ctrl_d.we     = 1'b0;
    ctrl_d.mtr    = 1'b0;
    ctrl_d.jump   = 1'b0;
    ctrl_d.branch = 1'b0;
    ctrl_d.ill    = 1'b0;
    unique case (state_q)
      S_DEC: begin
        ctrl_d.mrd   = 1'b0;
        ctrl_d.mwr   = 1'b0;
        ctrl_d.stall = 1'b0;
        if (INSTR_VALID) begin
          if (!legal) begin
            ctrl_d.ill = 1'b1;
          end else begin
            unique case (op_lo)
              4'd0: begin ctrl_d.we = 1'b1; ctrl_d.aluop = ALU_FWD; ctrl_d.comp = 1'b0; ctrl_d.imm = 1'b1; end
              4'd1: begin ctrl_d.we = 1'b1; ctrl_d.aluop = ALU_FWD; ctrl_d.comp = 1'b0; ctrl_d.imm = 1'b0; end
              4'd2: begin ctrl_d.we = 1'b1; ctrl_d.aluop = ALU_ADD; ctrl_d.comp = 1'b0; ctrl_d.imm = 1'b0; end
              4'd3: begin ctrl_d.we = 1'b1; ctrl_d.aluop = ALU_ADD; ctrl_d.comp = 1'b1; ctrl_d.imm = 1'b0; end
              4'd4: begin ctrl_d.we = 1'b1; ctrl_d.aluop = ALU_AND; ctrl_d.comp = 1'b0; ctrl_d.imm = 1'b0; end
              4'd5: begin ctrl_d.we = 1'b1; ctrl_d.aluop = ALU_OR;  ctrl_d.comp = 1'b0; ctrl_d.imm = 1'b0; end
              4'd6: ctrl_d.jump = 1'b1;
              4'd7: begin ctrl_d.branch = 1'b1; ctrl_d.aluop = ALU_ADD; ctrl_d.comp = 1'b1; ctrl_d.imm = 1'b0; end
              default: begin
                // 8..11: lwd, lwi, swd, swi -- bit 1 selects store, bit 0 immediate
                ctrl_d.mrd   = !op_lo[1];
                ctrl_d.mwr   = op_lo[1];
                ctrl_d.aluop = ALU_FWD;
                ctrl_d.comp  = 1'b0;
                ctrl_d.imm   = op_lo[0];
                ctrl_d.stall = 1'b1;
              end
            endcase
          end
        end
      end
      S_MEM: begin
        if (done) begin
          ctrl_d.mrd   = 1'b0;
          ctrl_d.mwr   = 1'b0;
          ctrl_d.we    = ctrl_q.mrd;
          ctrl_d.mtr   = ctrl_q.mrd;
          ctrl_d.stall = ctrl_q.mrd;  // loads keep fetch stalled through writeback
        end else if (tmo) begin
          ctrl_d.mrd   = 1'b0;
          ctrl_d.mwr   = 1'b0;
          ctrl_d.stall = 1'b0;
        end
      end
      default: begin  // S_WB
        ctrl_d.mrd   = 1'b0;
        ctrl_d.mwr   = 1'b0;
        ctrl_d.stall = 1'b0;
      end
    endcase
  end

  assign WRITEENABLE     = ctrl_q.we;
  assign ALUOP           = ctrl_q.aluop;
  assign COMPLEMENT_FLAG = ctrl_q.comp;
  assign IMMEDIATE_FLAG  = ctrl_q.imm;
  assign MEM_TO_REG      = ctrl_q.mtr;
  assign JUMP            = ctrl_q.jump;
  assign BRANCH          = ctrl_q.branch;
  assign MEM_READ        = ctrl_q.mrd;
  assign MEM_WRITE       = ctrl_q.mwr;
  assign PC_STALL        = ctrl_q.stall;
  assign ILLEGAL         = ctrl_q.ill;

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Testbench for ctrl_unit_mc: directed scenarios plus a randomized instruction
// stream, checked cycle by cycle against a transaction-level reference model.
module tb_ctrl_unit_mc;
  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        INSTR_VALID = 1'b0;
  logic        BUSYWAIT = 1'b0;
  logic        WRITEENABLE, COMPLEMENT_FLAG, IMMEDIATE_FLAG, MEM_TO_REG;
  logic        JUMP, BRANCH, MEM_READ, MEM_WRITE, PC_STALL, ILLEGAL, MEM_ERR;
  logic [2:0]  ALUOP;

  ctrl_unit_mc #(.OPCODE_W(8), .ALUOP_W(3), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .BUSYWAIT(BUSYWAIT), .WRITEENABLE(WRITEENABLE), .ALUOP(ALUOP),
    .COMPLEMENT_FLAG(COMPLEMENT_FLAG), .IMMEDIATE_FLAG(IMMEDIATE_FLAG),
    .MEM_TO_REG(MEM_TO_REG), .JUMP(JUMP), .BRANCH(BRANCH), .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE), .PC_STALL(PC_STALL), .ILLEGAL(ILLEGAL), .MEM_ERR(MEM_ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Architecturally held operand controls, as the model sees them.
  logic [2:0] h_alu  = '0;
  logic       h_comp = 1'b0;
  logic       h_imm  = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (we,alu3,comp,imm,mtr,j,b,rd,wr,stall,ill,merr) t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs();
    return {2'b0, WRITEENABLE, ALUOP, COMPLEMENT_FLAG, IMMEDIATE_FLAG, MEM_TO_REG,
            JUMP, BRANCH, MEM_READ, MEM_WRITE, PC_STALL, ILLEGAL, MEM_ERR};
  endfunction

  function automatic logic [15:0] ev(logic we, logic mtr, logic j, logic b, logic mr,
                                     logic mw, logic st, logic il, logic me);
    return {2'b0, we, h_alu, h_comp, h_imm, mtr, j, b, mr, mw, st, il, me};
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic bw,
                      input logic [15:0] e, input string tag);
    INSTRUCTION = ins;
    INSTR_VALID = v;
    BUSYWAIT    = bw;
    @(posedge CLK);
    #1 chk(tag, obs(), e);
  endtask

  task automatic idle(input string tag);
    step(1'b0, $urandom, 1'($urandom), ev(0,0,0,0,0,0,0,0,0), tag);
  endtask

  task automatic model_reset();
    h_alu = '0; h_comp = 1'b0; h_imm = 1'b0;
  endtask

  // Issue one instruction; k = number of S_MEM edges (from the first) with BUSYWAIT=1.
  task automatic do_instr(input logic [31:0] ins, input int k);
    logic [7:0] op;
    logic       ld;
    logic       tmo;
    int         c;
    op = ins[7:0];
    if (op > 8'd11) begin
      step(1'b1, ins, 1'($urandom), ev(0,0,0,0,0,0,0,1,0), "illegal");
    end else if (op < 8'd8) begin
      case (op)
        8'd0: begin h_alu = 3'd0; h_comp = 0; h_imm = 1; end
        8'd1: begin h_alu = 3'd0; h_comp = 0; h_imm = 0; end
        8'd2: begin h_alu = 3'd1; h_comp = 0; h_imm = 0; end
        8'd3: begin h_alu = 3'd1; h_comp = 1; h_imm = 0; end
        8'd4: begin h_alu = 3'd2; h_comp = 0; h_imm = 0; end
        8'd5: begin h_alu = 3'd3; h_comp = 0; h_imm = 0; end
        8'd7: begin h_alu = 3'd1; h_comp = 1; h_imm = 0; end
        default: ;
      endcase
      if (op == 8'd6)      step(1'b1, ins, 1'($urandom), ev(0,0,1,0,0,0,0,0,0), "jump");
      else if (op == 8'd7) step(1'b1, ins, 1'($urandom), ev(0,0,0,1,0,0,0,0,0), "beq");
      else                 step(1'b1, ins, 1'($urandom), ev(1,0,0,0,0,0,0,0,0), "alu");
    end else begin
      ld     = (op < 8'd10);
      h_alu  = 3'd0;
      h_comp = 1'b0;
      h_imm  = op[0];
      c      = (k + 1 > 2) ? k + 1 : 2;  // edge on which the access completes
      tmo    = 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
      if (c > TO) begin c = TO; tmo = 1'b1; end
`endif
      step(1'b1, ins, 1'($urandom), ev(0,0,0,0,ld,!ld,1,0,0), "mem_req");
      for (int j = 1; j < c; j++)
        step(1'($urandom), $urandom, (j <= k), ev(0,0,0,0,ld,!ld,1,0,0), "mem_wait");
      if (tmo)     step(1'($urandom), $urandom, (c <= k), ev(0,0,0,0,0,0,0,0,1), "mem_tmo");
      else if (ld) step(1'($urandom), $urandom, (c <= k), ev(1,1,0,0,0,0,1,0,0), "mem_wb");
      else         step(1'($urandom), $urandom, (c <= k), ev(0,0,0,0,0,0,0,0,0), "st_done");
      if (ld && !tmo) idle("wb_exit");
    end
  endtask

  initial begin
    logic [31:0] ins;
    // Reset state
    @(posedge CLK);
    #1 chk("reset", obs(), 16'h0);
    RESET = 1'b1;
    idle("idle0");

    // Reset asserted mid-stream takes effect immediately
    do_instr(32'h0000_0002, 0);
    do_instr(32'h0000_0003, 0);
    #2 RESET = 1'b0;
    #1 chk("rst_async", obs(), 16'h0);
    model_reset();
    @(posedge CLK);
    #1 RESET = 1'b1;

    // Back-to-back loadi, add, sub
    do_instr(32'h1234_5600, 0);
    do_instr(32'h0102_0302, 0);
    do_instr(32'hFFFF_0003, 0);
    idle("idle1");

    // Load with 3 busy cycles, store with none
    do_instr(32'h0000_0008, 3);
    do_instr(32'h0000_000B, 0);
    do_instr(32'h0000_000A, 1);
    do_instr(32'h0000_0009, 2);

    // Control flow and illegal opcodes
    do_instr(32'h0000_0006, 0);
    do_instr(32'h0000_0007, 0);
    do_instr(32'h0000_001F, 0);
    do_instr(32'h0000_0012, 0);
    do_instr(32'h0000_000C, 0);
    idle("idle2");

    // Reset during the second S_MEM cycle of a load aborts it with no writeback
    h_alu = 3'd0; h_comp = 1'b0; h_imm = 1'b1;
    step(1'b1, 32'h0000_0009, 1'b1, ev(0,0,0,0,1,0,1,0,0), "rma_req");
    step(1'b0, 32'h0, 1'b1, ev(0,0,0,0,1,0,1,0,0), "rma_wait");
    #2 RESET = 1'b0;
    #1 chk("rma_rst", obs(), 16'h0);
    model_reset();
    @(posedge CLK);
    #1 RESET = 1'b1;
    BUSYWAIT = 1'b0;
    for (int i = 0; i < 4; i++) idle("rma_after");

`ifdef CTRL_MEM_TIMEOUT_EN
    // Stuck BUSYWAIT aborts the access on the TO-th S_MEM edge
    do_instr(32'h0000_0008, 10);
    do_instr(32'h0000_000A, 10);
    do_instr(32'h0000_0008, TO - 1);
`endif

    // Randomized stream
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        idle("rnd_idle");
      end else begin
        ins = $urandom;
        if ($urandom_range(0, 7) == 0) ins[7:0] = 8'($urandom_range(12, 255));
        else                            ins[7:0] = 8'($urandom_range(0, 11));
        do_instr(ins, int'($urandom_range(0, 6)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got=running exp=finished");
    $fatal(1, "time bound expired");
  end
endmodule
